// File: rtl/unpad_halfkb.sv
// unpad_halfkb: validates a single-block SHA256 padded message, recovers the
// message length and writes the original bytes back into the byte-wide
// message SRAM starting at address 0.
module unpad_halfkb #(
  parameter int MAX_MESSAGE_LENGTH = 55,
  parameter int SYMBOL_WIDTH       = 8,
  parameter int ADDR_W             = $clog2(MAX_MESSAGE_LENGTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    go_sig,
  input  logic [511:0]            pad_mem,
  output logic                    msg_mem_en,
  output logic                    msg_mem_write,
  output logic [ADDR_W-1:0]       msg_mem_addr,
  output logic [SYMBOL_WIDTH-1:0] msg_mem_data,
  output logic [ADDR_W-1:0]       msg_len,
  output logic                    unpad_done,
  output logic                    pad_err
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    WRITE,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [511:0]        blk_q;
  logic                load_blk;
  logic [ADDR_W-1:0]   len_d;
  logic                err_d;

  logic                en_d;
  logic                wr_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [SYMBOL_WIDTH-1:0] data_d;
  logic                done_d;

  // Byte view of the captured block: byte 0 is the most significant byte.
  logic [7:0] blk_byte [64];

  genvar g;
  generate
    for (g = 0; g < 64; g++) begin : g_bytes
      assign blk_byte[g] = blk_q[511-8*g -: 8];
    end
  endgenerate

  // Full-width length in bytes; the truncated copy is only trusted once the
  // full value has been range-checked, so oversized fields cannot wrap.
  logic [60:0]       len_field;
  logic [ADDR_W-1:0] len_short;
  logic [MAX_MESSAGE_LENGTH:0] tail_nz;
  logic              len_in_range;
  logic              pad_ok;

  assign len_field    = blk_q[63:3];
  assign len_short    = blk_q[ADDR_W+2:3];
  assign len_in_range = (len_field <= 61'(MAX_MESSAGE_LENGTH));

  // Flags any nonzero byte between the 0x80 marker and the length field.
  generate
    for (g = 0; g <= MAX_MESSAGE_LENGTH; g++) begin : g_tail
      assign tail_nz[g] = (ADDR_W'(g) > len_short) && (blk_byte[g] != 8'h00);
    end
  endgenerate

  assign pad_ok = (blk_q[2:0] == 3'b000) && len_in_range &&
                  (blk_byte[len_short] == 8'h80) && !(|tail_nz);

  // Next-state, bookkeeping and next-output decode for the unpad sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_blk = 1'b0;
    len_d    = msg_len;
    err_d    = pad_err;
    en_d     = 1'b0;
    wr_d     = 1'b0;
    addr_d   = '0;
    data_d   = '0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (go_sig) begin
          load_blk = 1'b1;
          len_d    = '0;
          err_d    = 1'b0;
          cnt_d    = '0;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        cnt_d = '0;
        if (!pad_ok) begin
          err_d   = 1'b1;
          len_d   = '0;
          state_d = DONE;
        end else if (len_short == '0) begin
          len_d   = '0;
          state_d = DONE;
        end else begin
          len_d   = len_short;
          state_d = WRITE;
        end
      end
      WRITE: begin
        en_d   = 1'b1;
        wr_d   = 1'b1;
        addr_d = cnt_q;
        data_d = blk_byte[cnt_q];
        cnt_d  = cnt_q + ADDR_W'(1);
        if (cnt_q == msg_len - ADDR_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register plus the captured block and the length/error results.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
      msg_len <= '0;
      pad_err <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      msg_len <= len_d;
      pad_err <= err_d;
      if (load_blk) begin
        blk_q <= pad_mem;
      end
    end
  end

  // Registered SRAM port and completion pulse, one cycle behind the decode.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      msg_mem_en    <= 1'b0;
      msg_mem_write <= 1'b0;
      msg_mem_addr  <= '0;
      msg_mem_data  <= '0;
      unpad_done    <= 1'b0;
    end else begin
      msg_mem_en    <= en_d;
      msg_mem_write <= wr_d;
      msg_mem_addr  <= addr_d;
      msg_mem_data  <= data_d;
      unpad_done    <= done_d;
    end
  end

endmodule

// File: tb/tb_unpad_halfkb.sv
// tb_unpad_halfkb: scoreboard bench for unpad_halfkb. Stimulus pushes the
// expected writes and completion into queues; a negedge monitor pops them.
module tb_unpad_halfkb;

  logic         clock = 1'b0;
  logic         reset;
  logic         go_sig;
  logic [511:0] pad_mem;
  logic         msg_mem_en;
  logic         msg_mem_write;
  logic [5:0]   msg_mem_addr;
  logic [7:0]   msg_mem_data;
  logic [5:0]   msg_len;
  logic         unpad_done;
  logic         pad_err;

  unpad_halfkb dut (
    .clock        (clock),
    .reset        (reset),
    .go_sig       (go_sig),
    .pad_mem      (pad_mem),
    .msg_mem_en   (msg_mem_en),
    .msg_mem_write(msg_mem_write),
    .msg_mem_addr (msg_mem_addr),
    .msg_mem_data (msg_mem_data),
    .msg_len      (msg_len),
    .unpad_done   (unpad_done),
    .pad_err      (pad_err)
  );

  always #5 clock = ~clock;

  int cycle = 0;
  always @(posedge clock) cycle <= cycle + 1;

  logic [7:0] sram [64];
  always @(posedge clock) begin
    if (msg_mem_en && msg_mem_write) sram[msg_mem_addr] <= msg_mem_data;
  end

  typedef struct { int addr; int data; int cyc; } wr_t;
  typedef struct { int len; int err; int cyc; } dn_t;
  wr_t exp_w[$];
  dn_t exp_d[$];

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] msg_buf [56];

  task automatic checkOutput(input string name, input longint got, input longint expv);
    n_checks++;
    if (got != expv) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, expv, cycle);
    end
  endtask

  // Monitor: compare every presented write and every completion pulse.
  always @(negedge clock) begin
    wr_t w;
    dn_t d;
    if (!reset) begin
      if (msg_mem_en) begin
        if (exp_w.size() == 0) begin
          n_checks++;
          n_err++;
          $display("[TB] FAIL unexpected_write: addr %0d data %0h at cycle %0d, none expected",
                   msg_mem_addr, msg_mem_data, cycle);
        end else begin
          w = exp_w.pop_front();
          checkOutput("write_addr", msg_mem_addr, w.addr);
          checkOutput("write_data", msg_mem_data, w.data);
          checkOutput("write_cycle", cycle, w.cyc);
          checkOutput("write_strobe", msg_mem_write, 1);
        end
      end else if (msg_mem_write || msg_mem_addr != 0 || msg_mem_data != 0) begin
        n_checks++;
        n_err++;
        $display("[TB] FAIL idle_bus: write %0b addr %0d data %0h, expected all 0",
                 msg_mem_write, msg_mem_addr, msg_mem_data);
      end
      if (unpad_done) begin
        if (exp_d.size() == 0) begin
          n_checks++;
          n_err++;
          $display("[TB] FAIL unexpected_done: at cycle %0d, none expected", cycle);
        end else begin
          d = exp_d.pop_front();
          checkOutput("done_cycle", cycle, d.cyc);
          checkOutput("msg_len", msg_len, d.len);
          checkOutput("pad_err", pad_err, d.err);
          checkOutput("writes_missing", (exp_w.size() != 0 && exp_w[0].cyc <= cycle) ? 1 : 0, 0);
        end
      end
    end
  end

  // Reference padder: message bytes, 0x80 marker, zeros, 64-bit bit length.
  function automatic logic [511:0] makeBlock(input int len);
    logic [511:0] b;
    b = '0;
    for (int i = 0; i < len; i++) b[511-8*i -: 8] = msg_buf[i];
    b[511-8*len -: 8] = 8'h80;
    b[63:0] = 64'(len * 8);
    return b;
  endfunction

  // Push the expected response of one operation accepted at edge k.
  task automatic pushExpected(input logic [511:0] blk, input int k, input bit with_done);
    logic [7:0] b [64];
    longint unsigned lfield;
    bit err;
    int L;
    dn_t d;
    wr_t w;
    for (int i = 0; i < 64; i++) b[i] = blk[511-8*i -: 8];
    lfield = 64'(blk[63:3]);
    err = (blk[2:0] != 3'b000) || (lfield > 55);
    L = 0;
    if (!err) begin
      L = int'(lfield);
      if (b[L] != 8'h80) err = 1;
      for (int i = L + 1; i < 56; i++) if (b[i] != 8'h00) err = 1;
    end
    if (err) L = 0;
    for (int i = 0; i < L; i++) begin
      w.addr = i; w.data = b[i]; w.cyc = k + 2 + i;
      exp_w.push_back(w);
    end
    if (with_done) begin
      d.len = L; d.err = err ? 1 : 0; d.cyc = k + 2 + L;
      exp_d.push_back(d);
    end
  endtask

  task automatic drainOrRecover(input string name);
    int t;
    t = 0;
    while (exp_d.size() != 0 && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (exp_d.size() != 0) begin
      n_checks++;
      n_err++;
      $display("[TB] FAIL %s timeout: got no completion, expected unpad_done", name);
      exp_d.delete();
      exp_w.delete();
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [511:0] blk, input string name);
    int k;
    @(negedge clock);
    pad_mem = blk;
    go_sig  = 1'b1;
    @(negedge clock);
    k = cycle;
    go_sig = 1'b0;
    pushExpected(blk, k, 1'b1);
    drainOrRecover(name);
    @(negedge clock);
  endtask

  task automatic runMessage(input int len, input string name);
    int mism;
    for (int i = 0; i < 64; i++) sram[i] = 8'hEE;
    applyStimulus(makeBlock(len), name);
    mism = 0;
    for (int i = 0; i < len; i++) if (sram[i] !== msg_buf[i]) mism++;
    if (len < 64 && sram[len] !== 8'hEE) mism++;
    checkOutput({name, "_readback"}, mism, 0);
  endtask

  function automatic logic [511:0] abcBlock();
    msg_buf[0] = 8'h61; msg_buf[1] = 8'h62; msg_buf[2] = 8'h63;
    return makeBlock(3);
  endfunction

  // Stimulus sequence: directed cases from the plan, then randomized blocks.
  initial begin
    logic [511:0] blk;
    int k;
    int len;
    int mode;

    reset   = 1'b1;
    go_sig  = 1'b0;
    pad_mem = '0;
    for (int i = 0; i < 64; i++) sram[i] = 8'hEE;
    repeat (3) @(negedge clock);
    checkOutput("reset_en", msg_mem_en, 0);
    checkOutput("reset_write", msg_mem_write, 0);
    checkOutput("reset_addr", msg_mem_addr, 0);
    checkOutput("reset_data", msg_mem_data, 0);
    checkOutput("reset_len", msg_len, 0);
    checkOutput("reset_done", unpad_done, 0);
    checkOutput("reset_err", pad_err, 0);
    reset = 1'b0;
    @(negedge clock);

    blk = abcBlock();
    runMessage(3, "abc");
    runMessage(0, "empty");
    for (int i = 0; i < 55; i++) msg_buf[i] = 8'(i);
    runMessage(55, "max55");

    blk = abcBlock(); blk[63:0] = 64'h19;
    applyStimulus(blk, "err_unaligned");
    blk = abcBlock(); blk[63:0] = 64'h1C0;
    applyStimulus(blk, "err_len56");
    blk = abcBlock(); blk[63:0] = 64'h218;
    applyStimulus(blk, "err_len67_wrap");
    blk = abcBlock(); blk[511-8*20 -: 8] = 8'h01;
    applyStimulus(blk, "err_tail_nonzero");
    blk = abcBlock(); blk[511-8*3 -: 8] = 8'h00;
    applyStimulus(blk, "err_no_marker");
    blk = makeBlock(0); blk[63:0] = 64'h8000_0000_0000_0000;
    applyStimulus(blk, "err_len_2p63");

    for (int i = 0; i < 7; i++) msg_buf[i] = 8'($urandom);
    runMessage(7, "loopback7");

    // go held high for 20 edges: one operation per IDLE visit (every 6 edges).
    blk = abcBlock();
    @(negedge clock);
    pad_mem = blk;
    go_sig  = 1'b1;
    @(negedge clock);
    k = cycle;
    for (int a = 0; a < 20; a += 6) pushExpected(blk, k + a, 1'b1);
    repeat (19) @(negedge clock);
    go_sig = 1'b0;
    drainOrRecover("go_held");
    repeat (8) @(negedge clock);

    // Reset after the second write of the 55-byte case.
    for (int i = 0; i < 55; i++) msg_buf[i] = 8'(i);
    for (int i = 0; i < 64; i++) sram[i] = 8'hEE;
    blk = makeBlock(55);
    @(negedge clock);
    pad_mem = blk;
    go_sig  = 1'b1;
    @(negedge clock);
    k = cycle;
    go_sig = 1'b0;
    pushExpected(blk, k, 1'b0);
    while (exp_w.size() > 3) void'(exp_w.pop_back());
    repeat (4) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset_en", msg_mem_en, 0);
    checkOutput("midreset_write", msg_mem_write, 0);
    checkOutput("midreset_addr", msg_mem_addr, 0);
    checkOutput("midreset_data", msg_mem_data, 0);
    checkOutput("midreset_done", unpad_done, 0);
    checkOutput("midreset_len", msg_len, 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    checkOutput("midreset_pending", exp_w.size(), 0);
    exp_w.delete();
    checkOutput("midreset_sram0", sram[0], 0);
    checkOutput("midreset_sram1", sram[1], 1);
    begin
      int touched;
      touched = 0;
      for (int i = 2; i < 64; i++) if (sram[i] !== 8'hEE) touched++;
      checkOutput("midreset_no_late_writes", touched, 0);
    end
    repeat (3) @(negedge clock);
    blk = abcBlock();
    runMessage(3, "abc_after_reset");

    for (int n = 0; n < 40; n++) begin
      len = $urandom_range(0, 55);
      for (int i = 0; i < 56; i++) msg_buf[i] = 8'($urandom);
      blk  = makeBlock(len);
      mode = $urandom_range(0, 3);
      if (mode == 0) begin
        runMessage(len, "rand_valid");
      end else begin
        if (mode == 1) blk[$urandom_range(0, 511)] ^= 1'b1;
        else if (mode == 2) blk[63:0] = {32'($urandom), 32'($urandom)};
        else blk[63:0] = 64'($urandom_range(0, 60) * 8 + (($urandom_range(0, 3) == 0) ? 1 : 0));
        applyStimulus(blk, "rand_mutated");
      end
    end

    repeat (5) @(negedge clock);
    checkOutput("leftover_expectations", exp_w.size() + exp_d.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
